// File: rtl/sram_router_pkg.sv
// Shared constants and types for the SRAM channel router.
package sram_router_pkg;

   function automatic int calc_ch_bits(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   localparam int CH_BITS = calc_ch_bits(3);

   // Order-FIFO entries are {err, ch}; err set marks a read to a missing channel.
   localparam logic ORD_ERR = 1'b1;

   typedef enum logic {
      RSP_IDLE = 1'b0,
      RSP_SEND = 1'b1
   } rsp_state_t;

endpackage

// File: rtl/sram_chan_router_if.sv
// User-side request/response bus of the SRAM channel router.
interface sram_chan_router_if #(
   parameter int ADDR_W = 21,
   parameter int DATA_W = 72,
   parameter int BW_W   = 8
);
   logic              req_valid;
   logic              req_ready;
   logic              req_wr;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_data;
   logic [BW_W-1:0]   req_bw_n;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_err;

   modport master (output req_valid, req_wr, req_addr, req_data, req_bw_n,
                   input  req_ready, rsp_valid, rsp_data, rsp_err);
   modport slave  (input  req_valid, req_wr, req_addr, req_data, req_bw_n,
                   output req_ready, rsp_valid, rsp_data, rsp_err);
endinterface

// File: rtl/sram_router_fifo.sv
// Synchronous show-ahead FIFO; DEPTH must be a power of two >= 2.
module sram_router_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             memclk,
   input  logic             memreset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      count;
   logic             do_push, do_pop;

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge memclk or negedge memreset_n) begin
      if (!memreset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge memclk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end
endmodule

// File: rtl/sram_chan_router.sv
// Routes user requests to per-channel QDRII controllers and returns reads in order.
// state    | meaning
// RSP_IDLE | no response presented this cycle
// RSP_SEND | rsp_valid high with the entry popped on the previous cycle
module sram_chan_router
   import sram_router_pkg::*;
#(
   parameter int NUM_CHANNELS   = 3,
   parameter int MEM_ADDR_WIDTH = 19,
   parameter int MEM_WIDTH      = 36,
   parameter int MEM_BW_WIDTH   = 4,
   parameter int ORDER_DEPTH    = 16,
   parameter int RET_DEPTH      = 8
) (
   input  logic                                     memclk,
   input  logic                                     memreset_n,
   sram_chan_router_if.slave                        bus,
   output logic [NUM_CHANNELS-1:0]                  user_ad_w_n,
   output logic [NUM_CHANNELS-1:0]                  user_d_w_n,
   output logic [NUM_CHANNELS-1:0]                  user_r_n,
   output logic [NUM_CHANNELS*MEM_ADDR_WIDTH-1:0]   user_ad_wr,
   output logic [NUM_CHANNELS*MEM_ADDR_WIDTH-1:0]   user_ad_rd,
   output logic [NUM_CHANNELS*2*MEM_WIDTH-1:0]      user_dw,
   output logic [NUM_CHANNELS*2*MEM_BW_WIDTH-1:0]   user_bw_n,
   input  logic [NUM_CHANNELS-1:0]                  user_wr_full,
   input  logic [NUM_CHANNELS-1:0]                  user_rd_full,
   input  logic [NUM_CHANNELS-1:0]                  user_qr_valid,
   input  logic [NUM_CHANNELS-1:0]                  cal_done,
   input  logic [NUM_CHANNELS*2*MEM_WIDTH-1:0]      user_qr,
   output logic                                     all_cal_done
);
   localparam int CHB  = calc_ch_bits(NUM_CHANNELS);
   localparam int NPAD = 1 << CHB;
   localparam int DW   = 2*MEM_WIDTH;
   localparam int BWW  = 2*MEM_BW_WIDTH;
   localparam int CW   = $clog2(RET_DEPTH) + 1;
   localparam int OW   = CHB + 1;

   logic [CHB-1:0]            req_ch, head_ch;
   logic [MEM_ADDR_WIDTH-1:0] req_word;
   logic                      oor, run, accept, wr_hit, rd_hit;
   logic [NPAD-1:0]           wr_ok, rd_ok, ret_ne;
   logic [DW-1:0]             ret_q [NPAD];
   logic [CW-1:0]             out_cnt [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0]   ret_full, ret_empty, ret_push, ret_pop, rd_inc;
   logic [OW-1:0]             ord_head;
   logic                      ord_full, ord_empty, head_err, pop_ord;
   rsp_state_t                rsp_state;
   logic                      rsp_err_q;
   logic [DW-1:0]             rsp_data_q;

   assign req_ch       = bus.req_addr[CHB+MEM_ADDR_WIDTH-1 -: CHB];
   assign req_word     = bus.req_addr[MEM_ADDR_WIDTH-1:0];
   assign oor          = ({1'b0, req_ch} >= (CHB+1)'(NUM_CHANNELS));
   assign all_cal_done = &cal_done;

   // Missing channels never backpressure; OOR reads only need an order slot.
   assign bus.req_ready = run & all_cal_done &
                          (bus.req_wr ? (oor | wr_ok[req_ch])
                                      : (~ord_full & (oor | rd_ok[req_ch])));
   assign accept = bus.req_valid & bus.req_ready;
   assign wr_hit = accept &  bus.req_wr & ~oor;
   assign rd_hit = accept & ~bus.req_wr & ~oor;

   assign head_err = ord_head[CHB];
   assign head_ch  = ord_head[CHB-1:0];
   assign pop_ord  = ~ord_empty & (head_err | ret_ne[head_ch]);

   always_comb begin
      wr_ok    = '0;
      rd_ok    = '0;
      ret_ne   = '0;
      ret_push = '0;
      ret_pop  = '0;
      rd_inc   = '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         wr_ok[c]    = ~user_wr_full[c];
         rd_ok[c]    = ~user_rd_full[c] & (out_cnt[c] < CW'(RET_DEPTH));
         ret_ne[c]   = ~ret_empty[c];
         ret_push[c] = user_qr_valid[c] & (out_cnt[c] != '0) & ~ret_full[c];
         ret_pop[c]  = pop_ord & ~head_err & (head_ch == CHB'(c));
         rd_inc[c]   = rd_hit & (req_ch == CHB'(c));
      end
   end

   always_ff @(posedge memclk or negedge memreset_n) begin
      if (!memreset_n) begin
         run         <= 1'b0;
         user_ad_w_n <= '1;
         user_d_w_n  <= '1;
         user_r_n    <= '1;
         user_ad_wr  <= '0;
         user_ad_rd  <= '0;
         user_dw     <= '0;
         user_bw_n   <= '0;
         for (int c = 0; c < NUM_CHANNELS; c++) out_cnt[c] <= '0;
      end else begin
         run <= 1'b1;
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            user_ad_w_n[c] <= ~(wr_hit && req_ch == CHB'(c));
            user_d_w_n[c]  <= ~(wr_hit && req_ch == CHB'(c));
            user_r_n[c]    <= ~rd_inc[c];
            if (wr_hit && req_ch == CHB'(c)) begin
               user_ad_wr[c*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH] <= req_word;
               user_dw[c*DW +: DW]                             <= bus.req_data;
               user_bw_n[c*BWW +: BWW]                         <= bus.req_bw_n;
            end
            if (rd_inc[c]) user_ad_rd[c*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH] <= req_word;
            case ({rd_inc[c], ret_pop[c]})
               2'b10:   out_cnt[c] <= out_cnt[c] + CW'(1);
               2'b01:   out_cnt[c] <= out_cnt[c] - CW'(1);
               default: out_cnt[c] <= out_cnt[c];
            endcase
         end
      end
   end

   sram_router_fifo #(.WIDTH(OW), .DEPTH(ORDER_DEPTH)) u_order (
      .memclk     (memclk),
      .memreset_n (memreset_n),
      .push       (accept & ~bus.req_wr),
      .wr_data    (oor ? {ORD_ERR, req_ch} : {~ORD_ERR, req_ch}),
      .pop        (pop_ord),
      .rd_data    (ord_head),
      .full       (ord_full),
      .empty      (ord_empty)
   );

   for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ret
      sram_router_fifo #(.WIDTH(DW), .DEPTH(RET_DEPTH)) u_ret (
         .memclk     (memclk),
         .memreset_n (memreset_n),
         .push       (ret_push[c]),
         .wr_data    (user_qr[c*DW +: DW]),
         .pop        (ret_pop[c]),
         .rd_data    (ret_q[c]),
         .full       (ret_full[c]),
         .empty      (ret_empty[c])
      );
   end
   for (genvar c = NUM_CHANNELS; c < NPAD; c++) begin : g_pad
      assign ret_q[c] = '0;
   end

   always_ff @(posedge memclk or negedge memreset_n) begin
      if (!memreset_n) begin
         rsp_state  <= RSP_IDLE;
         rsp_err_q  <= 1'b0;
         rsp_data_q <= '0;
      end else if (pop_ord) begin
         rsp_state  <= RSP_SEND;
         rsp_err_q  <= head_err;
         rsp_data_q <= head_err ? '0 : ret_q[head_ch];
      end else begin
         rsp_state  <= RSP_IDLE;
         rsp_err_q  <= 1'b0;
      end
   end

   assign bus.rsp_valid = (rsp_state == RSP_SEND);
   assign bus.rsp_err   = rsp_err_q;
   assign bus.rsp_data  = rsp_data_q;
endmodule
